vga_pixel_loader: RTL and testbench
===================================

# vga_pixel_loader

Frame-buffer stage directly upstream of the VGA controller. It accepts a framed byte stream (e.g. from a UART receiver), unpacks two 3-bit RGB pixels per byte into a dual-port pixel RAM, and serves the controller's 15-bit `addr` with registered `r`, `g`, `b` bits. Load traffic and scan-out run concurrently on one clock.

## Interface
- `ADDR_W`, default 15: pixel address width; RAM depth is 2^ADDR_W (32768 covers the controller's maximum address of 28859).
- `SYNC`, default 8'hA5: header sync byte.
- `clk`  in  1  system/pixel clock.
- `rst_n`  in  1  reset; one clock; asynchronous, active-low.
- `in_data`  in  8  stream byte.
- `in_valid`  in  1  `in_data` valid.
- `in_ready`  out  1  byte accepted when `in_valid && in_ready` at the rising edge of `clk`.
- `addr`  in  ADDR_W  read address from the VGA controller.
- `r`, `g`, `b`  out  1 each  pixel bits for `addr`.
- `busy`  out  1  high from sync accept until the last payload write.
- `done`  out  1  one-cycle pulse after the last payload write.
- `ovf`  out  1  sticky: write address wrapped past 2^ADDR_W-1.

## Operation
- Frame format: `SYNC`, `ADDR_H`, `ADDR_L`, `LEN_H`, `LEN_L`, then LEN payload bytes.
  - Start address = {ADDR_H, ADDR_L}[ADDR_W-1:0]; bit 15 is ignored.
  - LEN counts bytes, 16 bits, range 0..65535.
  - Payload byte: bits [6:4] = {r,g,b} of pixel n; bits [2:0] = pixel n+1; bits 7 and 3 are ignored.
- FSM states: IDLE, AH, AL, LH, LL, DATA0, DATA1.
  - IDLE: bytes other than `SYNC` are accepted and discarded. `SYNC` moves to AH, sets `busy`, and clears `ovf`.
  - AH → AL → LH → LL: each accepted byte advances one state.
  - LL: if LEN == 0, go to IDLE, pulse `done`, and drop `busy` on the next cycle. Otherwise go to DATA0.
  - DATA0: `in_ready` = 1. On accept, write the high pixel at `wptr`, latch the low pixel, increment `wptr`, go to DATA1.
  - DATA1: `in_ready` = 0. Write the latched pixel at `wptr`, increment `wptr`, decrement the remaining count.
    - If the count is nonzero, go to DATA0.
    - If the count reaches zero, go to IDLE and pulse `done`.
- In all header states and in IDLE, `in_ready` = 1. The payload rate is at most one byte per 2 cycles.
- `wptr` is ADDR_W bits and increments modulo 2^ADDR_W. Any increment from all-ones sets `ovf`. Writing continues after the wrap.
- SYNC bytes inside a payload are treated as data; there is no resync mid-frame.
- Read port:
  - {r,g,b} <= mem[addr] on every clock edge.
  - A read and a write to the same address in the same cycle return the old contents (read-first).

## Timing
- Reset values: state IDLE, `in_ready` 1, `busy` 0, `done` 0, `ovf` 0, `r`/`g`/`b` 0, `wptr` 0, count 0.
- RAM contents are not reset and are preserved across reset.
- Read latency: exactly 1 cycle from `addr` to `r`/`g`/`b`. The VGA controller compensates for this in its blanking alignment.
- Write latency: the high pixel is visible to reads 1 cycle after the byte is accepted; the low pixel is visible 2 cycles after.
- `in_ready` in DATA0/DATA1 depends only on the registered state, with no combinational path from `in_valid`.
- `done` is asserted in the cycle immediately after the last RAM write, for exactly 1 cycle. `busy` falls in the same cycle.
- Reset asserted mid-frame: the FSM returns to IDLE immediately. Partial writes remain in RAM, and no `done` is issued.
- `in_valid` low in any state: the FSM holds, with no timeout.

## Structure
- A shared package `vga_pkg` holds:
  - `ADDR_W`, `SYNC`
  - the FSM state enum
  - the pixel type `rgb_t` (3 bits)
- One sub-module, `pixel_ram`: simple dual-port, 2^ADDR_W x 3, one write port and one registered read port (read-first), inferable as block RAM. The FSM, pointer, and counter live in the top module.

## Test plan
- Reset, then a frame A5 00 10 00 02 71 25 → writes mem[16]=7, mem[17]=1, mem[18]=2, mem[19]=5. `done` pulses once. Reads with `addr`=16..19 return those values 1 cycle later.
- Garbage 00 FF 3C before A5 00 00 00 01 40 → the garbage is discarded. Then mem[0]=4 and mem[1]=0.
- LEN=0 frame A5 12 34 00 00 → no writes. `done` is 1 cycle after LL is accepted, and `busy` is low afterwards.
- Start address 7FFF, LEN=1, byte 0x77 → mem[7FFF]=7 and mem[0]=7. `ovf` is 1 until the next SYNC is accepted, then clears.
- With `in_valid` held high during a 4-byte payload → `in_ready` toggles 1,0,1,0,…. Reading the address being written in the same cycle returns the old value, and the new value on the next cycle.
- `rst_n` pulsed low after 1 payload byte of a 3-byte frame → outputs return to reset values. The already-written pixels persist, no `done` is issued, and the next valid frame loads correctly.

Source files
------------

// File: rtl/vga_pkg.sv
// Shared definitions for the VGA pixel loader: default geometry, the
// header sync byte, the loader FSM state encoding and the 3-bit pixel type.
package vga_pkg;

  localparam int unsigned ADDR_W = 15;
  localparam logic [7:0]  SYNC   = 8'hA5;

  typedef enum logic [2:0] {
    IDLE,
    AH,
    AL,
    LH,
    LL,
    DATA0,
    DATA1
  } state_e;

  // {r, g, b}
  typedef logic [2:0] rgb_t;

endpackage

// File: rtl/pixel_ram.sv
// Simple dual-port pixel RAM, 2^ADDR_W x 3, read-first.
// Ports:
//   clk, rst_n  clock and async active-low reset (read register only)
//   we_i        write enable
//   waddr_i     write address
//   wdata_i     write pixel
//   raddr_i     read address
//   rdata_o     registered read pixel, one cycle after raddr_i
module pixel_ram
  import vga_pkg::*;
#(
  parameter int unsigned ADDR_W = vga_pkg::ADDR_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  rgb_t              wdata_i,
  input  logic [ADDR_W-1:0] raddr_i,
  output rgb_t              rdata_o
);

  localparam int unsigned DEPTH = 2 ** ADDR_W;

  rgb_t mem_q [DEPTH];
  rgb_t rdata_q;

  // Storage is never reset so contents survive a loader reset.
  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  // Non-blocking read of the old word gives read-first behaviour on collisions.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata_q <= '0;
    end else begin
      rdata_q <= mem_q[raddr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/vga_pixel_loader.sv
// Frame-buffer loader: parses SYNC/ADDR/LEN framed byte stream, unpacks two
// pixels per payload byte into the pixel RAM, and serves VGA scan-out reads.
// Ports:
//   clk, rst_n          clock, async active-low reset
//   in_data/in_valid    stream byte and its valid
//   in_ready            byte accepted when in_valid && in_ready at posedge
//   addr                VGA read address
//   r, g, b             pixel bits for addr, one cycle later
//   busy                high from SYNC accept until the last payload write
//   done                one-cycle pulse after the last payload write
//   ovf                 sticky write-pointer wrap flag, cleared on SYNC
module vga_pixel_loader #(
  parameter int unsigned ADDR_W = vga_pkg::ADDR_W,
  parameter logic [7:0]  SYNC   = vga_pkg::SYNC
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [7:0]        in_data,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [ADDR_W-1:0] addr,
  output logic              r,
  output logic              g,
  output logic              b,
  output logic              busy,
  output logic              done,
  output logic              ovf
);

  import vga_pkg::*;

  state_e            state_q, state_d;
  logic [7:0]        hdr_q, hdr_d;
  logic [ADDR_W-1:0] wptr_q, wptr_d;
  logic [15:0]       cnt_q, cnt_d;
  rgb_t              pix_q, pix_d;
  logic              in_ready_q, in_ready_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              ovf_q, ovf_d;

  logic              accept_c;
  logic              we_c;
  rgb_t              wdata_c;
  rgb_t              rdata;

  assign accept_c = in_valid && in_ready_q;

  // Next-state, datapath and RAM write control.
  always_comb begin
    state_d = state_q;
    hdr_d   = hdr_q;
    wptr_d  = wptr_q;
    cnt_d   = cnt_q;
    pix_d   = pix_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    ovf_d   = ovf_q;
    we_c    = 1'b0;
    wdata_c = in_data[6:4];

    case (state_q)
      IDLE: begin
        if (accept_c && (in_data == SYNC)) begin
          state_d = AH;
          busy_d  = 1'b1;
          ovf_d   = 1'b0;
        end
      end
      AH: begin
        if (accept_c) begin
          hdr_d   = in_data;
          state_d = AL;
        end
      end
      AL: begin
        if (accept_c) begin
          wptr_d  = ADDR_W'({hdr_q, in_data});
          state_d = LH;
        end
      end
      LH: begin
        if (accept_c) begin
          hdr_d   = in_data;
          state_d = LL;
        end
      end
      LL: begin
        if (accept_c) begin
          cnt_d = {hdr_q, in_data};
          if ({hdr_q, in_data} == 16'd0) begin
            state_d = IDLE;
            done_d  = 1'b1;
            busy_d  = 1'b0;
          end else begin
            state_d = DATA0;
          end
        end
      end
      DATA0: begin
        if (accept_c) begin
          we_c    = 1'b1;
          pix_d   = in_data[2:0];
          wptr_d  = wptr_q + ADDR_W'(1);
          if (&wptr_q) begin
            ovf_d = 1'b1;
          end
          state_d = DATA1;
        end
      end
      DATA1: begin
        we_c    = 1'b1;
        wdata_c = pix_q;
        wptr_d  = wptr_q + ADDR_W'(1);
        if (&wptr_q) begin
          ovf_d = 1'b1;
        end
        cnt_d = cnt_q - 16'd1;
        if (cnt_q == 16'd1) begin
          state_d = IDLE;
          done_d  = 1'b1;
          busy_d  = 1'b0;
        end else begin
          state_d = DATA0;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Registered ready: only the low-pixel write cycle refuses input.
    in_ready_d = (state_d != DATA1);
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      hdr_q      <= '0;
      wptr_q     <= '0;
      cnt_q      <= '0;
      pix_q      <= '0;
      in_ready_q <= 1'b1;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      ovf_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      hdr_q      <= hdr_d;
      wptr_q     <= wptr_d;
      cnt_q      <= cnt_d;
      pix_q      <= pix_d;
      in_ready_q <= in_ready_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      ovf_q      <= ovf_d;
    end
  end

  pixel_ram #(
    .ADDR_W (ADDR_W)
  ) u_ram (
    .clk     (clk),
    .rst_n   (rst_n),
    .we_i    (we_c),
    .waddr_i (wptr_q),
    .wdata_i (wdata_c),
    .raddr_i (addr),
    .rdata_o (rdata)
  );

  assign {r, g, b} = rdata;
  assign in_ready  = in_ready_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_vga_pixel_loader.sv
// Directed bench for vga_pixel_loader: frame loads, wrap, zero-length,
// ready toggling, read-first collisions, mid-frame reset, RAM readback table.
module tb_vga_pixel_loader;

  localparam int unsigned AW = 15;

  typedef logic [7:0] byte_q_t [$];
  typedef struct {
    logic [AW-1:0] a;
    logic [2:0]    exp;
  } rd_vec_t;

  logic          clk      = 1'b0;
  logic          rst_n    = 1'b0;
  logic [7:0]    in_data  = 8'h00;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [AW-1:0] addr     = '0;
  logic          r, g, b;
  logic          busy, done, ovf;

  int checks     = 0;
  int failures   = 0;
  int done_seen  = 0;

  rd_vec_t tbl [17];
  byte_q_t q;
  logic [7:0] pl [4];

  vga_pixel_loader #(
    .ADDR_W (AW),
    .SYNC   (8'hA5)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_data  (in_data),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .addr     (addr),
    .r        (r),
    .g        (g),
    .b        (b),
    .busy     (busy),
    .done     (done),
    .ovf      (ovf)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (done) done_seen++;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Present a byte at the negedge and hold it until the accepting posedge.
  task automatic send_byte(input logic [7:0] bt);
    int n = 0;
    @(negedge clk);
    in_data  = bt;
    in_valid = 1'b1;
    while (!in_ready && n < 8) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      checks++;
      failures++;
      $display("FAIL in_ready_timeout: got 0 expected 1 at %0t", $time);
    end
    @(posedge clk);
  endtask

  task automatic send_seq(input byte_q_t s);
    foreach (s[i]) send_byte(s[i]);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic send_one(input logic [7:0] bt);
    send_byte(bt);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic wait_done(input string name);
    int n = 0;
    while (!done && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk({name, "_done"}, done, 1);
    chk({name, "_busy_low"}, busy, 0);
    @(negedge clk);
    chk({name, "_done_1cyc"}, done, 0);
  endtask

  task automatic read_chk(input logic [AW-1:0] a, input logic [2:0] exp, input string name);
    @(negedge clk);
    addr = a;
    @(negedge clk);
    chk(name, {r, g, b}, exp);
  endtask

  initial begin
    tbl[0]  = '{15'h0010, 3'd7};
    tbl[1]  = '{15'h0011, 3'd1};
    tbl[2]  = '{15'h0012, 3'd2};
    tbl[3]  = '{15'h0013, 3'd5};
    tbl[4]  = '{15'h0000, 3'd4};
    tbl[5]  = '{15'h0001, 3'd0};
    tbl[6]  = '{15'h7FFF, 3'd7};
    tbl[7]  = '{15'h0020, 3'd6};
    tbl[8]  = '{15'h0021, 3'd5};
    tbl[9]  = '{15'h0022, 3'd4};
    tbl[10] = '{15'h0023, 3'd3};
    tbl[11] = '{15'h0024, 3'd2};
    tbl[12] = '{15'h0025, 3'd1};
    tbl[13] = '{15'h0026, 3'd0};
    tbl[14] = '{15'h0027, 3'd7};
    tbl[15] = '{15'h0050, 3'd5};
    tbl[16] = '{15'h0060, 3'd2};

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_ovf", ovf, 0);
    chk("rst_rgb", {r, g, b}, 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_in_ready", in_ready, 1);

    // Basic frame at 16
    send_one(8'hA5);
    chk("t2_busy_after_sync", busy, 1);
    q = '{8'h00, 8'h10, 8'h00, 8'h02, 8'h71, 8'h25};
    send_seq(q);
    wait_done("t2");
    chk("t2_done_count", done_seen, 1);
    read_chk(15'h0013, 3'd5, "t2_read19");

    // Wrap past 7FFF, bit 15 of address ignored
    q = '{8'hA5, 8'hFF, 8'hFF, 8'h00, 8'h01, 8'h77};
    send_seq(q);
    wait_done("wrap");
    chk("wrap_ovf_set", ovf, 1);
    read_chk(15'h0000, 3'd7, "wrap_mem0");
    read_chk(15'h7FFF, 3'd7, "wrap_mem7fff");
    send_one(8'h00);
    chk("wrap_ovf_sticky", ovf, 1);

    // Zero-length frame; SYNC clears ovf
    send_one(8'hA5);
    chk("len0_ovf_cleared", ovf, 0);
    chk("len0_busy", busy, 1);
    q = '{8'h12, 8'h34, 8'h00, 8'h00};
    send_seq(q);
    chk("len0_done", done, 1);
    chk("len0_busy_low", busy, 0);
    @(negedge clk);
    chk("len0_done_1cyc", done, 0);
    chk("len0_done_count", done_seen, 3);

    // Garbage before SYNC is discarded
    send_one(8'h00);
    chk("garb0_busy", busy, 0);
    send_one(8'hFF);
    chk("garb1_busy", busy, 0);
    send_one(8'h3C);
    chk("garb2_busy", busy, 0);
    q = '{8'hA5, 8'h00, 8'h00, 8'h00, 8'h01, 8'h40};
    send_seq(q);
    wait_done("garb");

    // Preload 32..39 so the collision reads have known old contents
    q = '{8'hA5, 8'h00, 8'h20, 8'h00, 8'h04, 8'h12, 8'h34, 8'h56, 8'h70};
    send_seq(q);
    wait_done("pre");

    // Back-to-back payload with valid held high; read-first on address 33
    addr = 15'h0021;
    pl[0] = 8'h65; pl[1] = 8'h43; pl[2] = 8'h21; pl[3] = 8'h07;
    q = '{8'hA5, 8'h00, 8'h20, 8'h00, 8'h04};
    foreach (q[i]) send_byte(q[i]);
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      chk($sformatf("toggle_%0d", k), in_ready, (k % 2 == 0) ? 1 : 0);
      if (k % 2 == 0) in_data = pl[k/2];
      if (k == 1) chk("rf_before", {r, g, b}, 3'd2);
      if (k == 2) chk("rf_same_cycle", {r, g, b}, 3'd2);
      if (k == 3) chk("rf_next_cycle", {r, g, b}, 3'd5);
    end
    @(negedge clk);
    in_valid = 1'b0;
    chk("b2b_done", done, 1);
    chk("b2b_busy_low", busy, 0);
    @(negedge clk);
    chk("b2b_done_count", done_seen, 6);

    // Reset after one payload byte of a 3-byte frame
    q = '{8'hA5, 8'h00, 8'h50, 8'h00, 8'h03};
    send_seq(q);
    send_byte(8'h53);
    @(negedge clk);
    in_valid = 1'b0;
    rst_n    = 1'b0;
    #1;
    chk("mr_in_ready", in_ready, 1);
    chk("mr_busy", busy, 0);
    chk("mr_done", done, 0);
    chk("mr_ovf", ovf, 0);
    chk("mr_rgb", {r, g, b}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("mr_no_done", done_seen, 6);
    q = '{8'hA5, 8'h00, 8'h60, 8'h00, 8'h01, 8'h24};
    send_seq(q);
    wait_done("mr_next");
    read_chk(15'h0061, 3'd4, "mr_next_mem61");

    // Final RAM readback
    foreach (tbl[i]) read_chk(tbl[i].a, tbl[i].exp, $sformatf("mem_%0h", tbl[i].a));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
